// File: rtl/bp_perceptron_train_ctrl.sv
// Perceptron weight-table training sequencer: queues resolved branches and saturating-RMWs bias+weights of a row.
// Latency: 3*(GHRLen+1) cycles per trained entry minimum; skipped entries retire at one per cycle.
// Backpressure: ex_ready_o low when FIFO full (push then dropped, drop_o pulses); fetch owns port until StallLimit.
module bp_perceptron_train_ctrl #(
    parameter int PTableSize = 128,
    parameter int PWeightLen = 9,
    parameter int GHRLen     = 12,
    parameter int Theta      = 38,
    parameter int FifoDepth  = 4,
    parameter int StallLimit = 8,
    localparam int IdxW = $clog2(PTableSize),
    localparam int ColW = $clog2(GHRLen + 1),
    localparam int YW   = 2 * PWeightLen - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ex_br_valid_i,
    input  logic                  ex_br_taken_i,
    input  logic [31:0]           ex_br_instr_addr_i,
    input  logic [YW-1:0]         ex_br_yout_i,
    input  logic [GHRLen-1:0]     ex_br_ghr_i,
    output logic                  ex_ready_o,
    output logic                  drop_o,
    input  logic                  fetch_req_i,
    output logic                  fetch_gnt_o,
    output logic                  tbl_req_o,
    output logic                  tbl_we_o,
    output logic [IdxW-1:0]       tbl_index_o,
    output logic [ColW-1:0]       tbl_col_o,
    output logic [PWeightLen-1:0] tbl_wdata_o,
    input  logic [PWeightLen-1:0] tbl_rdata_i,
    output logic                  busy_o,
    output logic                  train_done_o
);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int StW  = $clog2(StallLimit + 1);
    localparam logic [PWeightLen-1:0] WMax = {1'b0, {(PWeightLen-1){1'b1}}};
    localparam logic [PWeightLen-1:0] WMin = {1'b1, {(PWeightLen-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    typedef struct packed {
        logic              taken;
        logic [IdxW-1:0]   idx;
        logic [YW-1:0]     yout;
        logic [GHRLen-1:0] ghr;
    } entry_t;

    state_t            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [StW-1:0]    stall_q, stall_d;
    logic              taken_q, taken_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [GHRLen-1:0] ghr_q, ghr_d;
    logic [PWeightLen-1:0] w_q, w_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              drop_q, drop_d;

    entry_t fifo_mem [FifoDepth];
    entry_t push_entry, head;
    logic   push, pop;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ex_br_instr_addr_i[31:IdxW+2], ex_br_instr_addr_i[1:0]};

    assign ex_ready_o = (count_q != CntW'(FifoDepth));
    assign push       = ex_br_valid_i & ex_ready_o;
    assign pop        = (state_q == IDLE) & (count_q != '0);
    assign head       = fifo_mem[rd_ptr_q];

    always_comb begin
        push_entry       = '0;
        push_entry.taken = ex_br_taken_i;
        push_entry.idx   = ex_br_instr_addr_i[IdxW+1:2];
        push_entry.yout  = ex_br_yout_i;
        push_entry.ghr   = ex_br_ghr_i;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= push_entry;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        drop_d = ex_br_valid_i & ~ex_ready_o;
    end

    // Magnitude carries one extra bit so the most-negative yout is represented exactly.
    logic signed [YW:0] y_ext;
    logic        [YW:0] mag;
    logic               pred, need_train;
    always_comb begin
        y_ext      = {head.yout[YW-1], head.yout};
        mag        = head.yout[YW-1] ? $unsigned(-y_ext) : $unsigned(y_ext);
        pred       = ~head.yout[YW-1];
        need_train = (pred != head.taken) | (mag < (YW+1)'(Theta));
    end

    // inc_vec[0] is the bias direction; inc_vec[j] agrees-with-history for weight j-1.
    logic [GHRLen:0]       inc_vec;
    logic                  inc;
    logic [PWeightLen-1:0] w_new;
    always_comb begin
        inc_vec = {~({GHRLen{taken_q}} ^ ghr_q), taken_q};
        inc     = inc_vec[col_q];
        if (inc) w_new = (w_q == WMax) ? w_q : w_q + PWeightLen'(1);
        else     w_new = (w_q == WMin) ? w_q : w_q - PWeightLen'(1);
    end

    logic want, force_own, own, last_col;
    assign want      = (state_q == RD) | (state_q == WR);
    assign force_own = (stall_q == StW'(StallLimit));
    assign own       = want & (~fetch_req_i | force_own);
    assign last_col  = (col_q == ColW'(GHRLen));

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        stall_d      = '0;
        taken_d      = taken_q;
        idx_d        = idx_q;
        ghr_d        = ghr_q;
        w_d          = w_q;
        train_done_o = 1'b0;
        if (want & ~own) stall_d = stall_q + StW'(1);
        case (state_q)
            IDLE: begin
                if (pop & need_train) begin
                    taken_d = head.taken;
                    idx_d   = head.idx;
                    ghr_d   = head.ghr;
                    col_d   = '0;
                    state_d = RD;
                end
            end
            RD: if (own) state_d = CAP;
            CAP: begin
                w_d     = tbl_rdata_i;
                state_d = WR;
            end
            WR: begin
                if (own) begin
                    if (last_col) begin
                        state_d      = IDLE;
                        train_done_o = 1'b1;
                    end else begin
                        col_d   = col_q + ColW'(1);
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            col_q    <= '0;
            stall_q  <= '0;
            taken_q  <= 1'b0;
            idx_q    <= '0;
            ghr_q    <= '0;
            w_q      <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            stall_q  <= stall_d;
            taken_q  <= taken_d;
            idx_q    <= idx_d;
            ghr_q    <= ghr_d;
            w_q      <= w_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    assign fetch_gnt_o = fetch_req_i & ~(want & force_own);
    assign tbl_req_o   = own;
    assign tbl_we_o    = own & (state_q == WR);
    assign tbl_index_o = idx_q;
    assign tbl_col_o   = col_q;
    assign tbl_wdata_o = (state_q == WR) ? w_new : '0;
    assign busy_o      = (state_q != IDLE);
    assign drop_o      = drop_q;
endmodule

// File: tb/tb_bp_perceptron_train_ctrl.sv
// Bench for bp_perceptron_train_ctrl: table-driven entries plus fetch-starvation, overflow and reset sequences.
module tb_bp_perceptron_train_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, taken;
    logic [31:0] addr;
    logic [15:0] yout;
    logic [11:0] ghr;
    logic        ex_ready, drop, fetch_req, fetch_gnt;
    logic        tbl_req, tbl_we, busy, train_done;
    logic [6:0]  tbl_index;
    logic [3:0]  tbl_col;
    logic [8:0]  tbl_wdata, tbl_rdata;

    always #5 clk = ~clk;

    bp_perceptron_train_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_br_valid_i(valid), .ex_br_taken_i(taken), .ex_br_instr_addr_i(addr),
        .ex_br_yout_i(yout), .ex_br_ghr_i(ghr),
        .ex_ready_o(ex_ready), .drop_o(drop),
        .fetch_req_i(fetch_req), .fetch_gnt_o(fetch_gnt),
        .tbl_req_o(tbl_req), .tbl_we_o(tbl_we), .tbl_index_o(tbl_index), .tbl_col_o(tbl_col),
        .tbl_wdata_o(tbl_wdata), .tbl_rdata_i(tbl_rdata),
        .busy_o(busy), .train_done_o(train_done)
    );

    // Weight table model: synchronous read, one-cycle read latency.
    logic [8:0] mem [128][13];
    logic       clr, pre_we;
    int         pre_row, pre_col;
    logic [8:0] pre_val;
    always @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < 128; r++)
                for (int c = 0; c < 13; c++) mem[r][c] <= '0;
        end else if (pre_we) begin
            mem[pre_row][pre_col] <= pre_val;
        end else if (tbl_req) begin
            if (tbl_we) mem[tbl_index][tbl_col] <= tbl_wdata;
            else        tbl_rdata <= mem[tbl_index][tbl_col];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int drop_cnt = 0;
    int done_cnt = 0;

    typedef struct {int row; int col; int val;} wr_t;
    wr_t sb_q[$];
    int  exp_mem [128][13];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            wr_t e;
            if (drop) drop_cnt++;
            if (train_done) done_cnt++;
            if (tbl_req) chk("port_exclusive", int'(fetch_gnt), 0);
            if (tbl_req && tbl_we) begin
                chk("write_expected", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("wr_row", int'(tbl_index), e.row);
                    chk("wr_col", int'(tbl_col), e.col);
                    chk("wr_val", int'($signed(tbl_wdata)), e.val);
                    chk("wr_done_flag", int'(train_done), int'(e.col == 12));
                end
            end else if (train_done) begin
                chk("done_without_write", int'(tbl_req & tbl_we), 1);
            end
        end
    end

    // Reference update: saturating +/-1 per column, applied in queue order.
    task automatic push_expect(input logic tk, input logic [11:0] gh, input int row);
        int  v;
        logic up;
        for (int c = 0; c < 13; c++) begin
            up = (c == 0) ? tk : (tk == gh[c-1]);
            v  = exp_mem[row][c];
            if (up) v = (v == 255) ? 255 : v + 1;
            else    v = (v == -256) ? -256 : v - 1;
            exp_mem[row][c] = v;
            sb_q.push_back('{row, c, v});
        end
    endtask

    task automatic drive(input logic tk, input logic [15:0] yo, input logic [11:0] gh, input int row);
        valid = 1'b1; taken = tk; yout = yo; ghr = gh; addr = 32'(row) << 2;
    endtask

    task automatic push(input logic tk, input logic [15:0] yo, input logic [11:0] gh, input int row);
        @(posedge clk); #1 drive(tk, yo, gh, row);
        @(posedge clk); #1 valid = 1'b0;
    endtask

    task automatic preload(input int row, input int col, input int val);
        @(posedge clk); #1 pre_we = 1'b1; pre_row = row; pre_col = col; pre_val = 9'(val);
        @(posedge clk); #1 pre_we = 1'b0;
        exp_mem[row][col] = val;
    endtask

    task automatic run_entry(input string nm, input logic tk, input logic [15:0] yo,
                             input logic [11:0] gh, input int row, input logic exp_tr,
                             input int exp_done);
        int   done_at = -1;
        int   reqs = 0;
        int   first_run = 0;
        logic seen_req = 1'b0;
        logic busy_seen = 1'b0;
        if (exp_tr) push_expect(tk, gh, row);
        push(tk, yo, gh, row);
        for (int cyc = 0; cyc < 400 && done_at < 0; cyc++) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
            if (tbl_req) begin reqs++; seen_req = 1'b1; end
            else if (cyc >= 1 && !seen_req && fetch_gnt) first_run++;
            if (train_done) done_at = cyc;
            if (!exp_tr && cyc >= 45) break;
        end
        @(posedge clk); #1;
        chk({nm, "_busy"}, int'(busy_seen), int'(exp_tr));
        if (exp_tr) begin
            chk({nm, "_done_cycle"}, done_at, exp_done);
            chk({nm, "_port_accesses"}, reqs, 26);
            if (fetch_req) chk({nm, "_first_fetch_run"}, first_run, 8);
        end
        chk({nm, "_sb_drained"}, sb_q.size(), 0);
    endtask

    typedef struct {
        string       nm;
        logic        tk;
        logic [15:0] yo;
        logic [11:0] gh;
        int          row;
        logic        tr;
        int          pcol;
        int          pval;
    } vec_t;
    vec_t vecs [10];

    initial begin
        int d0, c0, k;
        vecs[0] = '{"mispredict_all_inc", 1'b1, 16'hFFFB,  12'hFFF, 3,  1'b1, -1, 0};
        vecs[1] = '{"confident_skip",     1'b1, 16'd100,   12'h000, 10, 1'b0, -1, 0};
        vecs[2] = '{"mag37_trains",       1'b1, 16'd37,    12'h000, 11, 1'b1, -1, 0};
        vecs[3] = '{"mag38_skips",        1'b1, 16'd38,    12'h000, 12, 1'b0, -1, 0};
        vecs[4] = '{"most_neg_mispred",   1'b1, 16'h8000,  12'h000, 13, 1'b1, -1, 0};
        vecs[5] = '{"most_neg_correct",   1'b0, 16'h8000,  12'h000, 16, 1'b0, -1, 0};
        vecs[6] = '{"neg_confident",      1'b0, 16'hFF38,  12'h000, 14, 1'b0, -1, 0};
        vecs[7] = '{"pos_mispredict",     1'b0, 16'd200,   12'h0A5, 15, 1'b1, -1, 0};
        vecs[8] = '{"weight_sat_max",     1'b1, 16'hFFFB,  12'h001, 5,  1'b1, 1, 255};
        vecs[9] = '{"bias_sat_min",       1'b0, 16'd5,     12'h000, 6,  1'b1, 0, -256};

        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 13; c++) exp_mem[r][c] = 0;
        rst_n = 1'b0; clr = 1'b1; pre_we = 1'b0; pre_row = 0; pre_col = 0; pre_val = '0;
        valid = 1'b0; taken = 1'b0; addr = '0; yout = '0; ghr = '0; fetch_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_ready", int'(ex_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tbl_req", int'(tbl_req), 0);
        chk("rst_drop", int'(drop), 0);
        chk("rst_done", int'(train_done), 0);
        chk("rst_fetch_gnt", int'(fetch_gnt), 0);
        rst_n = 1'b1; clr = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].pcol >= 0) preload(vecs[i].row, vecs[i].pcol, vecs[i].pval);
            run_entry(vecs[i].nm, vecs[i].tk, vecs[i].yo, vecs[i].gh, vecs[i].row, vecs[i].tr, 39);
        end

        // Fetch holds the port: each access waits StallLimit cycles.
        fetch_req = 1'b1;
        run_entry("fetch_starve", 1'b1, 16'hFFFB, 12'h3C3, 60, 1'b1, 247);
        fetch_req = 1'b0;

        // Overflow: A trains, B..E fill the FIFO, F and G are dropped; B and D share a row.
        d0 = drop_cnt; c0 = done_cnt;
        push_expect(1'b1, 12'h0F0, 40);
        push(1'b1, 16'hFFFB, 12'h0F0, 40);
        push_expect(1'b1, 12'h00F, 41);
        push_expect(1'b0, 12'hAAA, 42);
        push_expect(1'b0, 12'h00F, 41);
        push_expect(1'b1, 12'h555, 43);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 3) chk("ovf_ready_after3", int'(ex_ready), 1);
            if (i == 4) chk("ovf_ready_after4", int'(ex_ready), 0);
            case (i)
                0: drive(1'b1, 16'hFFFB, 12'h00F, 41);
                1: drive(1'b0, 16'd9,    12'hAAA, 42);
                2: drive(1'b0, 16'd9,    12'h00F, 41);
                3: drive(1'b1, 16'hFFFB, 12'h555, 43);
                4: drive(1'b1, 16'hFFFB, 12'h111, 44);
                default: drive(1'b1, 16'hFFFB, 12'h222, 45);
            endcase
        end
        @(posedge clk); #1 valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("ovf_drop_pulses", drop_cnt - d0, 2);
        k = 0;
        while ((busy || sb_q.size() != 0 || !ex_ready || k < 2) && k < 2000) begin
            @(posedge clk); #1 k++;
        end
        chk("ovf_no_timeout", int'(k < 2000), 1);
        chk("ovf_trained_count", done_cnt - c0, 5);
        chk("ovf_sb_drained", sb_q.size(), 0);

        // Reset while the column-5 write is on the port.
        push_expect(1'b1, 12'hFFF, 50);
        push(1'b1, 16'hFFFB, 12'hFFF, 50);
        push(1'b1, 16'hFFFB, 12'hFFF, 51);
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!(tbl_req && tbl_we && tbl_col == 4'd5) && k < 500);
        chk("rst_mid_reached_col5", int'(k < 500), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tbl_req", int'(tbl_req), 0);
        chk("rst_mid_ex_ready", int'(ex_ready), 1);
        chk("rst_mid_busy", int'(busy), 0);
        sb_q.delete();
        for (int c = 5; c < 13; c++) exp_mem[50][c] = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) k++;
        end
        chk("rst_mid_fifo_flushed", k, 0);
        for (int c = 0; c < 6; c++) chk("rst_mid_row_kept", int'($signed(mem[50][c])), (c < 5) ? 1 : 0);
        chk("rst_mid_row51_untouched", int'($signed(mem[51][0])), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
